drive_ctrl: RTL
===============

# drive_ctrl

Decision stage between the sensor front-ends and the motor driver on the line-following car. It consumes the ultrasonic `distance` word and the 2-bit line-tracker state and produces the 2-bit `mode` command for the motor block. Its job is to:
- debounce obstacle detection with hysteresis;
- hold turns for a minimum time to stop chatter;
- recover from a lost line, then halt if recovery fails.

## Interface
- TICK_DIV, 100000, clk cycles per decision tick (1 ms at 100 MHz)
- STOP_DIST, 20'd1500, distance strictly below this counts as near
- GO_DIST, 20'd2000, distance at or above this counts as far (must be ≥ STOP_DIST)
- OBS_CNT, 8, consecutive near ticks to assert obstacle
- CLR_CNT, 8, consecutive far ticks to clear obstacle
- HOLD_TICKS, 50, minimum ticks spent in a turn state
- SEARCH_TICKS, 500, ticks of lost line in SEARCH before HALT

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- distance  in  20  sonic_top range, same units as STOP_DIST/GO_DIST
- tracker_state  in  2  00 centred, 01 line left, 10 line right, 11 line lost
- mode  out  2  motor command: 00 STOP, 01 FWD, 10 LEFT, 11 RIGHT (registered)
- state_o  out  3  FSM state: 0 FOLLOW, 1 TURN_L, 2 TURN_R, 3 SEARCH, 4 BLOCKED, 5 HALT
- obstacle  out  1  filtered obstacle flag (registered)

## Operation
**Tick generator**
- tick_cnt counts 0..TICK_DIV-1 and wraps.
- tick is high for exactly one cycle, when tick_cnt == TICK_DIV-1.
- All filter and FSM updates happen only on tick cycles.

**Obstacle filter** (per tick)
- A distance of 0 (no echo) is treated as far.
- Near (d < STOP_DIST): near_cnt++ (saturates at OBS_CNT); far_cnt cleared.
- Far (d ≥ GO_DIST): far_cnt++ (saturates at CLR_CNT); near_cnt cleared.
- Between the thresholds: both counters hold.
- obstacle sets on the tick where near_cnt reaches OBS_CNT.
- obstacle clears on the tick where far_cnt reaches CLR_CNT.
- Otherwise obstacle holds.

**FSM** (evaluated on tick; rules in priority order)
1. Any state except HALT, with the filtered obstacle (value after this tick's update) equal to 1 → BLOCKED.
2. FOLLOW:
   - ts=01 → TURN_L
   - ts=10 → TURN_R
   - ts=11 → SEARCH
   - ts=00 → stay
3. TURN_L / TURN_R: stay until hold_cnt ≥ HOLD_TICKS. After that:
   - ts=00 → FOLLOW
   - opposite direction → other turn state
   - ts=11 → SEARCH
   - same direction → stay
4. SEARCH:
   - ts≠11 → FOLLOW
   - ts==11 when srch_cnt reaches SEARCH_TICKS → HALT
5. BLOCKED: obstacle==0 → FOLLOW.
6. HALT: ignores obstacle. ts=00 → FOLLOW; otherwise stay.

**Counters and direction memory**
- hold_cnt and srch_cnt clear on every state change.
- Both increment on each tick spent in the same state and saturate.
- last_dir is set to LEFT/RIGHT on entry to TURN_L/TURN_R. Reset value is LEFT.

**Mode per state**
- FOLLOW → FWD
- TURN_L → LEFT
- TURN_R → RIGHT
- SEARCH → last_dir
- BLOCKED / HALT → STOP

## Timing
**Reset** (asynchronous assert, synchronous release on next clk):
- state BLOCKED, mode 00, state_o 4, obstacle 0.
- All counters 0; last_dir LEFT.
- The first tick after reset moves the FSM to FOLLOW, so mode becomes 01 TICK_DIV cycles after release.
- Reset asserted mid-operation forces the outputs above immediately, without waiting for clk.

**Output registration**
- mode, state_o and obstacle are registered from next-state values.
- All three change on the same clk edge, the edge ending the tick cycle.

**Latency**
- Tracker change → mode: ≤ TICK_DIV cycles.
- Obstacle assert: OBS_CNT consecutive near ticks.
- Obstacle clear: CLR_CNT consecutive far ticks.

**Simultaneous events**
- Obstacle beats any tracker transition.
- SEARCH reaching SEARCH_TICKS with ts≠11 on the same tick → FOLLOW.

Counter widths are $clog2(limit+1). Saturation prevents wrap-around.

## Test plan
Bench parameters: TICK_DIV=4, OBS_CNT=3, CLR_CNT=3, HOLD_TICKS=2, SEARCH_TICKS=5, STOP_DIST=100, GO_DIST=150.

1. Reset: release rst, ts=00, d=500 → mode=00/state_o=4 until 4 cycles after release, then mode=01/state_o=0.
2. Obstacle hysteresis: d=50 for 3 ticks → obstacle=1, mode=00, state_o=4. Then d=120 for 10 ticks → still blocked. Then d=200 for 3 ticks → obstacle=0, FOLLOW. A d=50 blip of 2 ticks in FOLLOW → no change.
3. Turn hold: ts=01 → TURN_L, mode=10. Set ts=00 after 1 tick → remain TURN_L until hold_cnt=2, then FOLLOW.
4. Lost line: from TURN_R set ts=11 → SEARCH, mode=11. After 5 lost ticks → HALT, mode=00. ts=10 keeps HALT; ts=00 → FOLLOW.
5. Priority: in TURN_L with d=50 qualifying on the same tick ts goes to 10 → BLOCKED, not TURN_R. In HALT, d=50 → remains HALT, obstacle=1.
6. Async reset mid-turn: assert rst between clk edges in TURN_L → mode=00, state_o=4, obstacle=0 immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/drive_ctrl.sv
// Decision stage for the line-following car: obstacle hysteresis filter, turn hold,
// lost-line search and halt, producing the registered motor command.
module drive_ctrl #(
  parameter int unsigned TICK_DIV     = 100000,
  parameter logic [19:0] STOP_DIST    = 20'd1500,
  parameter logic [19:0] GO_DIST      = 20'd2000,
  parameter int unsigned OBS_CNT      = 8,
  parameter int unsigned CLR_CNT      = 8,
  parameter int unsigned HOLD_TICKS   = 50,
  parameter int unsigned SEARCH_TICKS = 500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [19:0] distance,
  input  logic [1:0]  tracker_state,
  output logic [1:0]  mode,
  output logic [2:0]  state_o,
  output logic        obstacle
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int NW = $clog2(OBS_CNT + 1);
  localparam int FW = $clog2(CLR_CNT + 1);
  localparam int HW = $clog2(HOLD_TICKS + 1);
  localparam int SW = $clog2(SEARCH_TICKS + 1);

  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [NW-1:0] NEAR_MAX  = NW'(OBS_CNT);
  localparam logic [FW-1:0] FAR_MAX   = FW'(CLR_CNT);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_TICKS);
  localparam logic [SW-1:0] SRCH_MAX  = SW'(SEARCH_TICKS);

  localparam logic [1:0] M_STOP  = 2'b00;
  localparam logic [1:0] M_FWD   = 2'b01;
  localparam logic [1:0] M_LEFT  = 2'b10;
  localparam logic [1:0] M_RIGHT = 2'b11;

  typedef enum logic [2:0] {
    ST_FOLLOW  = 3'd0,
    ST_TURN_L  = 3'd1,
    ST_TURN_R  = 3'd2,
    ST_SEARCH  = 3'd3,
    ST_BLOCKED = 3'd4,
    ST_HALT    = 3'd5
  } state_e;

  state_e        state_q, state_d, st_upd_s;
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic [NW-1:0] near_cnt_q, near_cnt_d, near_upd_s;
  logic [FW-1:0] far_cnt_q, far_cnt_d, far_upd_s;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d, hold_inc_s, hold_upd_s;
  logic [SW-1:0] srch_cnt_q, srch_cnt_d, srch_inc_s, srch_upd_s;
  logic          obs_q, obs_d, obs_upd_s;
  logic          last_dir_q, last_dir_d, dir_upd_s;  // 0 = LEFT, 1 = RIGHT
  logic [1:0]    mode_q, mode_d;
  logic          tick_s, near_s, far_s;

  function automatic logic [1:0] mode_of(input state_e st, input logic dir_right);
    case (st)
      ST_FOLLOW: mode_of = M_FWD;
      ST_TURN_L: mode_of = M_LEFT;
      ST_TURN_R: mode_of = M_RIGHT;
      ST_SEARCH: mode_of = dir_right ? M_RIGHT : M_LEFT;
      default:   mode_of = M_STOP;
    endcase
  endfunction

  // Tick strobe and hysteresis filter; a zero distance means no echo, hence far.
  always_comb begin
    tick_s = (tick_cnt_q == TICK_LAST);
    near_s = (distance != 20'd0) && (distance < STOP_DIST);
    far_s  = (distance == 20'd0) || (distance >= GO_DIST);
    near_upd_s = near_cnt_q;
    far_upd_s  = far_cnt_q;
    if (near_s) begin
      near_upd_s = (near_cnt_q == NEAR_MAX) ? near_cnt_q : near_cnt_q + NW'(1);
      far_upd_s  = '0;
    end else if (far_s) begin
      far_upd_s  = (far_cnt_q == FAR_MAX) ? far_cnt_q : far_cnt_q + FW'(1);
      near_upd_s = '0;
    end else begin
      near_upd_s = near_cnt_q;
      far_upd_s  = far_cnt_q;
    end
    if (near_s && (near_upd_s == NEAR_MAX)) begin
      obs_upd_s = 1'b1;
    end else if (far_s && (far_upd_s == FAR_MAX)) begin
      obs_upd_s = 1'b0;
    end else begin
      obs_upd_s = obs_q;
    end
  end

  // Next-state rules; the freshly filtered obstacle wins over every tracker move except in HALT.
  always_comb begin
    hold_inc_s = (hold_cnt_q == HOLD_MAX) ? hold_cnt_q : hold_cnt_q + HW'(1);
    srch_inc_s = (srch_cnt_q == SRCH_MAX) ? srch_cnt_q : srch_cnt_q + SW'(1);
    st_upd_s   = state_q;
    if ((state_q != ST_HALT) && obs_upd_s) begin
      st_upd_s = ST_BLOCKED;
    end else begin
      case (state_q)
        ST_FOLLOW: begin
          case (tracker_state)
            2'b01:   st_upd_s = ST_TURN_L;
            2'b10:   st_upd_s = ST_TURN_R;
            2'b11:   st_upd_s = ST_SEARCH;
            default: st_upd_s = ST_FOLLOW;
          endcase
        end
        ST_TURN_L, ST_TURN_R: begin
          if (hold_cnt_q >= HOLD_MAX) begin
            case (tracker_state)
              2'b00:   st_upd_s = ST_FOLLOW;
              2'b01:   st_upd_s = ST_TURN_L;
              2'b10:   st_upd_s = ST_TURN_R;
              default: st_upd_s = ST_SEARCH;
            endcase
          end else begin
            st_upd_s = state_q;
          end
        end
        ST_SEARCH: begin
          if (tracker_state != 2'b11) begin
            st_upd_s = ST_FOLLOW;
          end else if (srch_inc_s == SRCH_MAX) begin
            st_upd_s = ST_HALT;
          end else begin
            st_upd_s = ST_SEARCH;
          end
        end
        ST_BLOCKED: begin
          if (!obs_upd_s) begin
            st_upd_s = ST_FOLLOW;
          end else begin
            st_upd_s = ST_BLOCKED;
          end
        end
        ST_HALT: begin
          if (tracker_state == 2'b00) begin
            st_upd_s = ST_FOLLOW;
          end else begin
            st_upd_s = ST_HALT;
          end
        end
        default: st_upd_s = ST_BLOCKED;
      endcase
    end
  end

  // Dwell counters restart on any state change; direction memory latches on turn entry.
  always_comb begin
    if (st_upd_s != state_q) begin
      hold_upd_s = '0;
      srch_upd_s = '0;
    end else begin
      hold_upd_s = hold_inc_s;
      srch_upd_s = srch_inc_s;
    end
    if ((st_upd_s == ST_TURN_L) && (state_q != ST_TURN_L)) begin
      dir_upd_s = 1'b0;
    end else if ((st_upd_s == ST_TURN_R) && (state_q != ST_TURN_R)) begin
      dir_upd_s = 1'b1;
    end else begin
      dir_upd_s = last_dir_q;
    end
  end

  // Commit the tick-cycle results; between ticks everything holds.
  always_comb begin
    tick_cnt_d = tick_s ? '0 : tick_cnt_q + TW'(1);
    if (tick_s) begin
      near_cnt_d = near_upd_s;
      far_cnt_d  = far_upd_s;
      obs_d      = obs_upd_s;
      state_d    = st_upd_s;
      hold_cnt_d = hold_upd_s;
      srch_cnt_d = srch_upd_s;
      last_dir_d = dir_upd_s;
      mode_d     = mode_of(st_upd_s, dir_upd_s);
    end else begin
      near_cnt_d = near_cnt_q;
      far_cnt_d  = far_cnt_q;
      obs_d      = obs_q;
      state_d    = state_q;
      hold_cnt_d = hold_cnt_q;
      srch_cnt_d = srch_cnt_q;
      last_dir_d = last_dir_q;
      mode_d     = mode_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_cnt_q <= '0;
      near_cnt_q <= '0;
      far_cnt_q  <= '0;
      obs_q      <= 1'b0;
      state_q    <= ST_BLOCKED;
      hold_cnt_q <= '0;
      srch_cnt_q <= '0;
      last_dir_q <= 1'b0;
      mode_q     <= M_STOP;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      near_cnt_q <= near_cnt_d;
      far_cnt_q  <= far_cnt_d;
      obs_q      <= obs_d;
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      srch_cnt_q <= srch_cnt_d;
      last_dir_q <= last_dir_d;
      mode_q     <= mode_d;
    end
  end

  assign mode     = mode_q;
  assign state_o  = state_q;
  assign obstacle = obs_q;

endmodule
